// File: rtl/btn_move_pulse.sv
// Paddle button conditioning: 2-FF synchroniser, debounce, press detection and
// vsync-locked auto-repeat, producing one-cycle btn_up / btn_down move requests.
module btn_move_pulse #(
   parameter int DEBOUNCE_CYCLES      = 650000,
   parameter int REPEAT_DELAY_FRAMES  = 20,
   parameter int REPEAT_PERIOD_FRAMES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_up_raw,
   input  logic btn_down_raw,
   input  logic vsync,
   output logic btn_up,
   output logic btn_down
);

   localparam int CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int FRAME_MAX = (REPEAT_DELAY_FRAMES > REPEAT_PERIOD_FRAMES) ?
                              REPEAT_DELAY_FRAMES : REPEAT_PERIOD_FRAMES;
   localparam int FRAME_W   = $clog2(FRAME_MAX + 1);

   localparam logic [CNT_W-1:0]   DB_LIMIT    = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
   localparam logic [FRAME_W-1:0] DELAY_LOAD  = FRAME_W'(REPEAT_DELAY_FRAMES);
   localparam logic [FRAME_W-1:0] PERIOD_LOAD = FRAME_W'(REPEAT_PERIOD_FRAMES);
   localparam logic [FRAME_W-1:0] FRAME_ONE   = FRAME_W'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRE   = 2'd1,
      HOLD   = 2'd2,
      REPEAT = 2'd3
   } state_t;

   typedef enum logic {
      DIR_UP = 1'b0,
      DIR_DN = 1'b1
   } dir_t;

   logic               up_s1_q,   up_s1_d;
   logic               up_s_q,    up_s_d;
   logic               down_s1_q, down_s1_d;
   logic               down_s_q,  down_s_d;
   logic [CNT_W-1:0]   up_cnt_q,  up_cnt_d;
   logic [CNT_W-1:0]   down_cnt_q, down_cnt_d;
   logic               up_db_q,   up_db_d;
   logic               down_db_q, down_db_d;
   logic               vsync_dly_q, vsync_dly_d;
   logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
   state_t             state_q,   state_d;
   dir_t               cur_dir_q, cur_dir_d;
   logic               btn_up_q,  btn_up_d;
   logic               btn_down_q, btn_down_d;

   logic               frame_tick;
   logic               dir_up;
   logic               dir_dn;
   logic               dir_held;

   // Two-flop synchronisers for the asynchronous raw buttons
   always_comb begin
      up_s1_d     = btn_up_raw;
      up_s_d      = up_s1_q;
      down_s1_d   = btn_down_raw;
      down_s_d    = down_s1_q;
      vsync_dly_d = vsync;
   end

   // The level flips on the edge after DEBOUNCE_CYCLES counted mismatches,
   // so any glitch must outlast DEBOUNCE_CYCLES before it is believed.
   always_comb begin
      up_cnt_d = up_cnt_q;
      up_db_d  = up_db_q;
      if (up_s_q == up_db_q) begin
         up_cnt_d = '0;
      end else if (up_cnt_q == DB_LIMIT) begin
         up_db_d  = up_s_q;
         up_cnt_d = '0;
      end else begin
         up_cnt_d = up_cnt_q + CNT_ONE;
      end
   end

   always_comb begin
      down_cnt_d = down_cnt_q;
      down_db_d  = down_db_q;
      if (down_s_q == down_db_q) begin
         down_cnt_d = '0;
      end else if (down_cnt_q == DB_LIMIT) begin
         down_db_d  = down_s_q;
         down_cnt_d = '0;
      end else begin
         down_cnt_d = down_cnt_q + CNT_ONE;
      end
   end

   assign frame_tick = vsync & ~vsync_dly_q;
   assign dir_up     = up_db_q & ~down_db_q;
   assign dir_dn     = down_db_q & ~up_db_q;

   always_comb begin
      dir_held = (cur_dir_q == DIR_UP) ? dir_up : dir_dn;
   end

   // Shared press/repeat FSM; frame ticks are only counted while in HOLD
   always_comb begin
      state_d     = state_q;
      cur_dir_d   = cur_dir_q;
      frame_cnt_d = frame_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (dir_up) begin
               state_d   = FIRE;
               cur_dir_d = DIR_UP;
            end else if (dir_dn) begin
               state_d   = FIRE;
               cur_dir_d = DIR_DN;
            end
         end
         FIRE: begin
            frame_cnt_d = DELAY_LOAD;
            state_d     = HOLD;
         end
         HOLD: begin
            if (!dir_held) begin
               state_d = IDLE;
            end else if (frame_tick) begin
               if (frame_cnt_q <= FRAME_ONE) begin
                  state_d = REPEAT;
               end else begin
                  frame_cnt_d = frame_cnt_q - FRAME_ONE;
               end
            end
         end
         REPEAT: begin
            frame_cnt_d = PERIOD_LOAD;
            state_d     = HOLD;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      btn_up_d   = ((state_q == FIRE) || (state_q == REPEAT)) && (cur_dir_q == DIR_UP);
      btn_down_d = ((state_q == FIRE) || (state_q == REPEAT)) && (cur_dir_q == DIR_DN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         up_s1_q     <= 1'b0;
         up_s_q      <= 1'b0;
         down_s1_q   <= 1'b0;
         down_s_q    <= 1'b0;
         up_cnt_q    <= '0;
         down_cnt_q  <= '0;
         up_db_q     <= 1'b0;
         down_db_q   <= 1'b0;
         vsync_dly_q <= 1'b0;
         frame_cnt_q <= '0;
         state_q     <= IDLE;
         cur_dir_q   <= DIR_UP;
         btn_up_q    <= 1'b0;
         btn_down_q  <= 1'b0;
      end else begin
         up_s1_q     <= up_s1_d;
         up_s_q      <= up_s_d;
         down_s1_q   <= down_s1_d;
         down_s_q    <= down_s_d;
         up_cnt_q    <= up_cnt_d;
         down_cnt_q  <= down_cnt_d;
         up_db_q     <= up_db_d;
         down_db_q   <= down_db_d;
         vsync_dly_q <= vsync_dly_d;
         frame_cnt_q <= frame_cnt_d;
         state_q     <= state_d;
         cur_dir_q   <= cur_dir_d;
         btn_up_q    <= btn_up_d;
         btn_down_q  <= btn_down_d;
      end
   end

   assign btn_up   = btn_up_q;
   assign btn_down = btn_down_q;

endmodule

// File: tb/tb_btn_move_pulse.sv
// Bench for btn_move_pulse: vector table, hand-written corner sequences and a
// randomized phase, all checked against an event-level reference model.
module tb_btn_move_pulse;

   localparam int D  = 4;
   localparam int RD = 3;
   localparam int RP = 2;
   localparam int VP = 50;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic up_raw = 1'b0;
   logic dn_raw = 1'b0;
   logic vsync = 1'b0;
   logic btn_up;
   logic btn_down;

   always #5 clk = ~clk;

   btn_move_pulse #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY_FRAMES(RD),
      .REPEAT_PERIOD_FRAMES(RP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_up_raw(up_raw),
      .btn_down_raw(dn_raw),
      .vsync(vsync),
      .btn_up(btn_up),
      .btn_down(btn_down)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int edge_no  = 0;
   int vcnt     = 0;
   int cnt_up   = 0;
   int cnt_dn   = 0;
   bit b_tick   = 0;
   bit b_vs_prev = 0;

   // Reference model: sampled input history, stable-window debounce and a
   // press "session" with a tick budget until the next scheduled pulse.
   bit       m_s1u = 0, m_su = 0, m_s1d = 0, m_sd = 0;
   bit       m_dbu = 0, m_dbd = 0;
   bit [D:0] win_u = '0, win_d = '0;
   bit       m_vs_prev = 0;
   int       sess = 0;
   bit       emit = 0;
   int       emit_dir = 0;
   int       ticks_left = 0;
   bit       exp_u = 0, exp_d = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_no, act, exp);
   endtask

   task automatic model_step();
      bit tick;
      bit blind;
      int dir;
      if (rst) begin
         m_s1u = 0; m_su = 0; m_s1d = 0; m_sd = 0;
         m_dbu = 0; m_dbd = 0; win_u = '0; win_d = '0;
         m_vs_prev = 0; sess = 0; emit = 0; emit_dir = 0; ticks_left = 0;
         exp_u = 0; exp_d = 0;
      end else begin
         tick = vsync && !m_vs_prev;
         dir  = (m_dbu && !m_dbd) ? 1 : ((m_dbd && !m_dbu) ? 2 : 0);
         exp_u = emit && (emit_dir == 1);
         exp_d = emit && (emit_dir == 2);
         blind = emit;
         emit  = 0;
         if (sess == 0) begin
            if (dir != 0) begin
               sess = dir; emit = 1; emit_dir = dir; ticks_left = RD;
            end
         end else if (!blind) begin
            if (dir != sess) sess = 0;
            else if (tick) begin
               ticks_left--;
               if (ticks_left == 0) begin
                  emit = 1; emit_dir = sess; ticks_left = RP;
               end
            end
         end
         win_u = {win_u[D-1:0], m_su};
         win_d = {win_d[D-1:0], m_sd};
         if (m_dbu ? (win_u == '0) : (&win_u)) m_dbu = !m_dbu;
         if (m_dbd ? (win_d == '0) : (&win_d)) m_dbd = !m_dbd;
         m_su = m_s1u; m_s1u = up_raw;
         m_sd = m_s1d; m_s1d = dn_raw;
         m_vs_prev = vsync;
      end
   endtask

   task automatic step();
      @(posedge clk);
      edge_no++;
      b_tick = vsync && !b_vs_prev;
      b_vs_prev = vsync;
      model_step();
      @(negedge clk);
      check("cycle_out", int'({btn_up, btn_down}), int'({exp_u, exp_d}));
      if (btn_up)   cnt_up++;
      if (btn_down) cnt_dn++;
      vcnt  = (vcnt + 1) % VP;
      vsync = (vcnt < 10);
   endtask

   task automatic settle(input int n);
      up_raw = 0; dn_raw = 0;
      for (int k = 0; k < n; k++) step();
   endtask

   typedef struct {
      string name;
      int    up_len;
      int    dn_len;
      int    run;
      int    exp_up;
      int    exp_dn;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int first;
      int p0;
      int r_edge;
      int t_cnt;
      int start;
      int exp_pulses;

      vecs[0] = '{"press_up",   20,  0, 40, 1, 0};
      vecs[1] = '{"press_dn",    0, 20, 40, 0, 1};
      vecs[2] = '{"glitch3_up",  3,  0, 20, 0, 0};
      vecs[3] = '{"glitch4_dn",  0,  4, 20, 0, 0};
      vecs[4] = '{"short5_up",   5,  0, 30, 1, 0};
      vecs[5] = '{"both_held",  20, 20, 40, 0, 0};
      vecs[6] = '{"short5_dn",   0,  5, 30, 0, 1};

      // Reset with both raw buttons asserted
      rst = 1; up_raw = 1; dn_raw = 1;
      for (int k = 0; k < 5; k++) begin
         step();
         check("rst_hold", int'({btn_up, btn_down}), 0);
      end
      rst = 0; dn_raw = 0;
      cnt_up = 0; cnt_dn = 0;
      step();
      check("rst_release", int'({btn_up, btn_down}), 0);
      for (int k = 0; k < 30; k++) step();
      check("rst_one_up", cnt_up, 1);
      check("rst_no_dn", cnt_dn, 0);
      settle(30);

      // Vector table
      for (int v = 0; v < 7; v++) begin
         cnt_up = 0; cnt_dn = 0;
         for (int k = 0; k < vecs[v].run; k++) begin
            up_raw = (k < vecs[v].up_len);
            dn_raw = (k < vecs[v].dn_len);
            step();
         end
         check({vecs[v].name, "_up"}, cnt_up, vecs[v].exp_up);
         check({vecs[v].name, "_dn"}, cnt_dn, vecs[v].exp_dn);
         settle(15);
      end

      // Single press latency: pulse on the step D+5 after the first sampled high
      cnt_up = 0; cnt_dn = 0; first = 0;
      up_raw = 1;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (btn_up && first == 0) first = k;
      end
      check("press_latency", first, D + 5);
      settle(30);
      check("press_once", cnt_up, 1);
      check("press_no_dn", cnt_dn, 0);

      // Glitch train on the down button
      cnt_up = 0; cnt_dn = 0;
      for (int g = 0; g < 5; g++) begin
         dn_raw = 1; for (int k = 0; k < 3; k++) step();
         dn_raw = 0; for (int k = 0; k < 5; k++) step();
      end
      settle(10);
      check("glitch_train", cnt_up + cnt_dn, 0);

      // Auto-repeat: pulses = 1 + repeats derived from ticks seen while held
      cnt_up = 0; cnt_dn = 0; p0 = 0; t_cnt = 0;
      start  = edge_no;
      r_edge = start + 601;
      for (int k = 1; k <= 640; k++) begin
         up_raw = (k <= 600);
         step();
         if (p0 == 0 && btn_up) p0 = edge_no;
         else if (p0 != 0 && b_tick && edge_no <= r_edge + D + 2) t_cnt++;
      end
      exp_pulses = 1 + ((t_cnt >= RD) ? (1 + (t_cnt - RD) / RP) : 0);
      check("repeat_total", cnt_up, exp_pulses);
      check("repeat_no_dn", cnt_dn, 0);
      check("repeat_seen", int'(cnt_up > 3), 1);
      settle(20);

      // Both pressed mid-HOLD, then release up
      up_raw = 1;
      for (int k = 0; k < 80; k++) step();
      dn_raw = 1;
      for (int k = 0; k < 20; k++) step();
      cnt_up = 0; cnt_dn = 0;
      for (int k = 0; k < 150; k++) step();
      check("both_quiet", cnt_up + cnt_dn, 0);
      up_raw = 0; first = 0;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (btn_down && first == 0) first = k;
      end
      check("swap_dn_latency", first, D + 5);
      check("swap_no_up", cnt_up, 0);
      for (int k = 0; k < 300; k++) step();
      check("swap_dn_repeats", int'(cnt_dn > 1), 1);
      settle(30);

      // Reset in the middle of a held repeat
      up_raw = 1;
      for (int k = 0; k < 120; k++) step();
      rst = 1;
      step();
      check("rst_mid", int'({btn_up, btn_down}), 0);
      rst = 0; first = 0;
      step();
      check("rst_mid_next", int'({btn_up, btn_down}), 0);
      for (int k = 2; k <= 20; k++) begin
         step();
         if (btn_up && first == 0) first = k;
      end
      check("rst_refire", first, D + 5);
      settle(30);

      // Randomized phase, checked every cycle against the model
      for (int it = 0; it < 40; it++) begin
         int len;
         if ($urandom_range(0, 9) == 0) begin
            rst = 1; step(); rst = 0;
         end
         up_raw = 1'($urandom_range(0, 1));
         dn_raw = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) len = $urandom_range(1, 8);
         else len = $urandom_range(10, 200);
         for (int k = 0; k < len; k++) step();
      end
      settle(20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
